// File: rtl/td4_core_param.sv
// Parametrised TD4 core: A/B/OUT/PC registers, carry flag, adder ALU and a RUN/HALT machine.
// Define TD4_EXT_OPS_EN to add ADD A,B (1000), JC (1010) and a carry-preserving NOP (1100).
module td4_core_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              RESUME,
    input  logic [DATA_W-1:0] IN,
    input  logic [DATA_W+3:0] ROM_DATA,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [DATA_W-1:0] OUT,
    output logic              HALTED
);
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              c_q, c_d;

    logic [3:0]        op;
    logic [DATA_W-1:0] imm, src, addend, res;
    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] pc_inc, jmp_tgt;

    assign op     = ROM_DATA[DATA_W+3:DATA_W];
    assign imm    = ROM_DATA[DATA_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    // Jump target: immediate zero-extended or truncated to the PC width.
    generate
        if (ADDR_W <= DATA_W) begin : g_tgt_trunc
            assign jmp_tgt = imm[ADDR_W-1:0];
        end else begin : g_tgt_ext
            assign jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, imm};
        end
    endgenerate

    always_comb begin
        src    = '0;
        addend = imm;
        case (op)
            4'b0000, 4'b0100:          src = a_q;
            4'b0001, 4'b0101, 4'b1001: src = b_q;
            4'b0010, 4'b0110:          src = IN;
`ifdef TD4_EXT_OPS_EN
            4'b1000: begin
                src    = a_q;
                addend = b_q;
            end
`endif
            default:                   src = '0;
        endcase
        sum = {1'b0, src} + {1'b0, addend};
        res = sum[DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        pc_d    = pc_q;
        c_d     = c_q;
        if (EN) begin
            case (state_q)
                S_RUN: begin
                    pc_d = pc_inc;
                    c_d  = sum[DATA_W];
                    case (op)
                        4'b0000, 4'b0001, 4'b0010, 4'b0011: a_d = res;
                        4'b0100, 4'b0101, 4'b0110, 4'b0111: b_d = res;
                        4'b1001, 4'b1011:                   out_d = res;
                        4'b1111:                            pc_d = jmp_tgt;
                        4'b1110: if (!c_q)                  pc_d = jmp_tgt;
                        4'b1101: begin
                            pc_d    = pc_q;
                            c_d     = c_q;
                            state_d = S_HALT;
                        end
`ifdef TD4_EXT_OPS_EN
                        4'b1000:                            a_d = res;
                        4'b1010: if (c_q)                   pc_d = jmp_tgt;
                        4'b1100:                            c_d = c_q;
`endif
                        default:                            c_d = 1'b0;
                    endcase
                end
                S_HALT: begin
                    if (RESUME) begin
                        state_d = S_RUN;
                        pc_d    = pc_inc;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_RUN;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            pc_q    <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            pc_q    <= pc_d;
            c_q     <= c_d;
        end
    end

    assign ROM_ADDR = pc_q;
    assign OUT      = out_q;
    assign HALTED   = (state_q == S_HALT);
endmodule
